// File: rtl/parser_gen.sv
// parser_gen: captures the first HDR_SEGS beats of a packet, looks up an action
// entry indexed by a header field, extracts big-endian fields into 2B/4B/6B
// containers and hands the resulting PHV downstream with valid/ready.

// One extraction lane: six bytes starting at the action offset, MSB first.
module parser_gen_lane #(
  parameter int HDR_BYTES = 128
) (
  input  logic [HDR_BYTES-1:0][7:0] hdr,
  input  logic [6:0]                off,
  output logic [47:0]               field
);
  localparam int BI = $clog2(HDR_BYTES);

  logic [7:0] b;

  // Bytes past the end of the header buffer read as zero.
  always_comb begin
    field = '0;
    b     = '0;
    for (int j = 0; j < 6; j++) begin
      b = {1'b0, off} + 8'(j);
      if (int'(b) < HDR_BYTES) field[8*(5-j) +: 8] = hdr[b[BI-1:0]];
    end
  end
endmodule

module parser_gen #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int HDR_SEGS             = 4,
  parameter int NUM_ACT              = 10,
  parameter int ACT_TBL_DEPTH        = 16,
  parameter int IDX_OFFSET           = 116,
  parameter int PHV_LEN              = 8*(48+32+16)+C_S_AXIS_TUSER_WIDTH
) (
  input  logic                               axis_clk,
  input  logic                               aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  output logic                               s_axis_tready,
  output logic [PHV_LEN-1:0]                 phv_out,
  output logic                               phv_valid,
  input  logic                               phv_ready,
  input  logic                               cfg_wr_en,
  input  logic [$clog2(ACT_TBL_DEPTH)-1:0]   cfg_wr_addr,
  input  logic [16*NUM_ACT-1:0]              cfg_wr_data,
  output logic [31:0]                        parsed_cnt
);
  localparam int DW        = C_S_AXIS_DATA_WIDTH;
  localparam int HB        = DW*HDR_SEGS;
  localparam int HDR_BYTES = HB/8;
  localparam int AW        = $clog2(ACT_TBL_DEPTH);
  localparam int EW        = 16*NUM_ACT;
  localparam int SEGW      = (HDR_SEGS > 1) ? $clog2(HDR_SEGS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_DRAIN   = 3'd2;
  localparam logic [2:0] S_LOOKUP  = 3'd3;
  localparam logic [2:0] S_EXTRACT = 3'd4;
  localparam logic [2:0] S_OUTPUT  = 3'd5;

  logic [2:0]                            state_q, state_d;
  logic [SEGW-1:0]                       seg_q, seg_d;
  logic [HDR_SEGS-1:0][DW-1:0]           hdr_buf_q, hdr_buf_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]       tuser_q, tuser_d;
  logic [ACT_TBL_DEPTH-1:0][EW-1:0]      tbl_q, tbl_d;
  logic [EW-1:0]                         entry_q, entry_d;
  logic [PHV_LEN-1:0]                    phv_q, phv_d;
  logic                                  phv_valid_q, phv_valid_d;
  logic [31:0]                           cnt_q, cnt_d;
  logic                                  ready_q, ready_d;

  logic [HB-1:0]                         hdr_flat;
  logic [AW-1:0]                         tbl_idx;
  logic                                  accept;
  logic [NUM_ACT-1:0][47:0]              field;
  logic [15:0]                           act;
  logic [7:0][15:0]                      c2;
  logic [7:0][31:0]                      c4;
  logic [7:0][47:0]                      c6;
  logic                                  unused_ok;

  assign hdr_flat      = hdr_buf_q;
  assign tbl_idx       = hdr_flat[IDX_OFFSET +: AW];
  assign s_axis_tready = ready_q;
  assign phv_out       = phv_q;
  assign phv_valid     = phv_valid_q;
  assign parsed_cnt    = cnt_q;
  assign unused_ok     = ^{s_axis_tkeep, act[15:6]};

  // Every action gets its own lane; the offset comes straight from the entry.
  for (genvar k = 0; k < NUM_ACT; k++) begin : g_lane
    parser_gen_lane #(.HDR_BYTES(HDR_BYTES)) u_lane (
      .hdr   (hdr_flat),
      .off   (entry_q[16*k+6 +: 7]),
      .field (field[k])
    );
  end

  // Route lanes into containers; ascending loop lets the highest action win.
  always_comb begin
    c2  = '0;
    c4  = '0;
    c6  = '0;
    act = '0;
    for (int k = 0; k < NUM_ACT; k++) begin
      act = entry_q[16*k +: 16];
      if (act[0]) begin
        case (act[2:1])
          2'b01:   c2[act[5:3]] = field[k][47:32];
          2'b10:   c4[act[5:3]] = field[k][47:16];
          2'b11:   c6[act[5:3]] = field[k];
          default: ;
        endcase
      end
    end
  end

  // Table writes land at the clock edge, so a same-cycle LOOKUP sees old data.
  always_comb begin
    tbl_d = tbl_q;
    if (cfg_wr_en) tbl_d[cfg_wr_addr] = cfg_wr_data;
  end

  // Packet FSM: capture, drain, lookup, extract, then hold the PHV.
  always_comb begin
    state_d     = state_q;
    seg_d       = seg_q;
    hdr_buf_d   = hdr_buf_q;
    tuser_d     = tuser_q;
    entry_d     = entry_q;
    phv_d       = phv_q;
    phv_valid_d = phv_valid_q;
    cnt_d       = cnt_q;
    accept      = s_axis_tvalid & ready_q;
    case (state_q)
      S_IDLE: if (accept) begin
        hdr_buf_d    = '0;
        hdr_buf_d[0] = s_axis_tdata;
        tuser_d      = s_axis_tuser;
        seg_d        = SEGW'(1);
        if (s_axis_tlast)      state_d = S_LOOKUP;
        else if (HDR_SEGS > 1) state_d = S_CAPTURE;
        else                   state_d = S_DRAIN;
      end
      S_CAPTURE: if (accept) begin
        hdr_buf_d[seg_q] = s_axis_tdata;
        if (s_axis_tlast)                         state_d = S_LOOKUP;
        else if (seg_q == SEGW'(HDR_SEGS - 1))    state_d = S_DRAIN;
        else                                      seg_d   = seg_q + 1'b1;
      end
      S_DRAIN: if (accept && s_axis_tlast) state_d = S_LOOKUP;
      S_LOOKUP: begin
        entry_d = tbl_q[tbl_idx];
        state_d = S_EXTRACT;
      end
      S_EXTRACT: begin
        phv_d       = {c6, c4, c2, tuser_q};
        phv_valid_d = 1'b1;
        state_d     = S_OUTPUT;
      end
      S_OUTPUT: if (phv_ready) begin
        phv_valid_d = 1'b0;
        cnt_d       = cnt_q + 32'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Ready is a flop of the next state so it never follows tvalid.
    ready_d = (state_d == S_IDLE) || (state_d == S_CAPTURE) || (state_d == S_DRAIN);
  end

  // State registers; reset abandons any packet in flight and clears the table.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      seg_q       <= '0;
      hdr_buf_q   <= '0;
      tuser_q     <= '0;
      tbl_q       <= '0;
      entry_q     <= '0;
      phv_q       <= '0;
      phv_valid_q <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      hdr_buf_q   <= hdr_buf_d;
      tuser_q     <= tuser_d;
      tbl_q       <= tbl_d;
      entry_q     <= entry_d;
      phv_q       <= phv_d;
      phv_valid_q <= phv_valid_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
    end
  end
endmodule
